// File: rtl/modulo_pkg.sv
// Shared types and defaults for the SECDED syndrome comparator / error locator.
package modulo_pkg;

    localparam int SYN_W = 4;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_SINGLE,
        ERR_DOUBLE
    } err_class_t;

    // Overall parity set means an odd number of flipped bits, so the error is locatable.
    function automatic err_class_t classify(input logic [SYN_W-1:0] d);
        if (d == '0)
            return ERR_NONE;
        else if (d[SYN_W-1])
            return ERR_SINGLE;
        else
            return ERR_DOUBLE;
    endfunction

endpackage

// File: rtl/syn_classify.sv
// Combinational classifier: error class plus one-hot location of a single error.
module syn_classify
    import modulo_pkg::*;
#(
    parameter int SYN_W = modulo_pkg::SYN_W
) (
    input  logic [SYN_W-1:0]          d,
    output err_class_t                err_class,
    output logic [2**(SYN_W-1)-1:0]   pos_onehot
);

    always_comb begin
        err_class  = classify(d);
        pos_onehot = '0;
        if (err_class == ERR_SINGLE)
            pos_onehot[d[SYN_W-2:0]] = 1'b1;
    end

endmodule

// File: rtl/modulo_03.sv
// Syndrome comparator and error locator with registered outputs and saturating statistics.
module modulo_03
    import modulo_pkg::*;
#(
    parameter int SYN_W = modulo_pkg::SYN_W,
    parameter int CNT_W = modulo_pkg::CNT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_in,
    input  logic [SYN_W-1:0]          sindrome_ref,
    input  logic [SYN_W-1:0]          sindrome_detec,
    output logic                      valid_out,
    output logic [SYN_W-1:0]          pos_error,
    output logic [2**(SYN_W-1)-1:0]   pos_onehot,
    output logic                      no_error,
    output logic                      single_error,
    output logic                      double_error,
    output logic [CNT_W-1:0]          single_cnt,
    output logic [CNT_W-1:0]          double_cnt
);

    logic [SYN_W-1:0]        syn_d;
    err_class_t              class_d;
    logic [2**(SYN_W-1)-1:0] onehot_d;

    logic                    valid_q;
    logic [SYN_W-1:0]        pos_q;
    logic [2**(SYN_W-1)-1:0] onehot_q;
    logic                    no_q, single_q, double_q;
    logic [CNT_W-1:0]        single_cnt_q, double_cnt_q;

    assign syn_d = sindrome_ref ^ sindrome_detec;

    syn_classify #(.SYN_W(SYN_W)) u_classify (
        .d          (syn_d),
        .err_class  (class_d),
        .pos_onehot (onehot_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            pos_q        <= '0;
            onehot_q     <= '0;
            no_q         <= 1'b0;
            single_q     <= 1'b0;
            double_q     <= 1'b0;
            single_cnt_q <= '0;
            double_cnt_q <= '0;
        end else begin
            valid_q <= valid_in;
            // Data and flags hold across idle cycles; only valid_out drops.
            if (valid_in) begin
                pos_q    <= syn_d;
                onehot_q <= onehot_d;
                no_q     <= (class_d == ERR_NONE);
                single_q <= (class_d == ERR_SINGLE);
                double_q <= (class_d == ERR_DOUBLE);
                if (class_d == ERR_SINGLE && single_cnt_q != '1)
                    single_cnt_q <= single_cnt_q + 1'b1;
                if (class_d == ERR_DOUBLE && double_cnt_q != '1)
                    double_cnt_q <= double_cnt_q + 1'b1;
            end
        end
    end

    assign valid_out    = valid_q;
    assign pos_error    = pos_q;
    assign pos_onehot   = onehot_q;
    assign no_error     = no_q;
    assign single_error = single_q;
    assign double_error = double_q;
    assign single_cnt   = single_cnt_q;
    assign double_cnt   = double_cnt_q;

endmodule

// File: tb/tb_modulo_03.sv
// Directed plus randomized bench for modulo_03 against an arithmetic reference model.
module tb_modulo_03;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_in;
    logic [3:0] sindrome_ref;
    logic [3:0] sindrome_detec;
    logic       valid_out;
    logic [3:0] pos_error;
    logic [7:0] pos_onehot;
    logic       no_error, single_error, double_error;
    logic [7:0] single_cnt, double_cnt;

    int checks = 0;
    int errors = 0;

    int e_valid, e_pos, e_oh, e_no, e_si, e_do, e_sc, e_dc;

    modulo_03 #(.SYN_W(4), .CNT_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .sindrome_ref   (sindrome_ref),
        .sindrome_detec (sindrome_detec),
        .valid_out      (valid_out),
        .pos_error      (pos_error),
        .pos_onehot     (pos_onehot),
        .no_error       (no_error),
        .single_error   (single_error),
        .double_error   (double_error),
        .single_cnt     (single_cnt),
        .double_cnt     (double_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".valid_out"},    int'(valid_out),    e_valid);
        check({ctx, ".pos_error"},    int'(pos_error),    e_pos);
        check({ctx, ".pos_onehot"},   int'(pos_onehot),   e_oh);
        check({ctx, ".no_error"},     int'(no_error),     e_no);
        check({ctx, ".single_error"}, int'(single_error), e_si);
        check({ctx, ".double_error"}, int'(double_error), e_do);
        check({ctx, ".single_cnt"},   int'(single_cnt),   e_sc);
        check({ctx, ".double_cnt"},   int'(double_cnt),   e_dc);
    endtask

    task automatic model_reset();
        e_valid = 0; e_pos = 0; e_oh = 0; e_no = 0;
        e_si = 0; e_do = 0; e_sc = 0; e_dc = 0;
    endtask

    // Reference rule: odd overall parity is a locatable single error, even nonzero is double.
    task automatic model_accept(input int r, input int dt);
        int d;
        d     = r ^ dt;
        e_pos = d;
        e_no  = (d == 0) ? 1 : 0;
        e_si  = (d >= 8) ? 1 : 0;
        e_do  = (d != 0 && d < 8) ? 1 : 0;
        e_oh  = (d >= 8) ? (1 << (d % 8)) : 0;
        if (e_si == 1 && e_sc < 255) e_sc++;
        if (e_do == 1 && e_dc < 255) e_dc++;
    endtask

    // Inputs are driven at the falling edge; outputs are checked at the next falling edge.
    task automatic step(input string ctx, input logic v, input logic [3:0] r, input logic [3:0] dt);
        valid_in       = v;
        sindrome_ref   = r;
        sindrome_detec = dt;
        @(posedge clk);
        e_valid = v ? 1 : 0;
        if (v) model_accept(int'(r), int'(dt));
        @(negedge clk);
        check_all(ctx);
    endtask

    initial begin
        rst_n = 1'b0;
        valid_in = 1'b0;
        sindrome_ref = '0;
        sindrome_detec = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        step("zero",   1'b1, 4'b0000, 4'b0000);
        step("dbl1",   1'b1, 4'b0000, 4'b0001);
        step("dbl3",   1'b1, 4'b0000, 4'b0011);
        step("sgl0",   1'b1, 4'b0000, 4'b1000);
        step("sgl2",   1'b1, 4'b0000, 4'b1010);
        step("sgl3",   1'b1, 4'b1101, 4'b0110);
        step("idle1",  1'b0, 4'b1111, 4'b0000);
        step("idle2",  1'b0, 4'b0101, 4'b0000);
        step("idle3",  1'b0, 4'b0011, 4'b1100);

        for (int i = 0; i < 200; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom));
        end

        // Asynchronous reset between edges must clear outputs without a clock.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b0, 4'b1000, 4'b0000);

        step("dbl_pre", 1'b1, 4'b0110, 4'b0000);
        for (int i = 0; i < 300; i++) begin
            step("sat", 1'b1, 4'b0000, 4'b1001);
        end
        check("sat.single_cnt_final", int'(single_cnt), 255);
        check("sat.double_cnt_final", int'(double_cnt), 1);

        for (int i = 0; i < 50; i++) begin
            step("rand2", 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
